prbs31_checker: RTL
===================

// Module: prbs31_checker
// PURPOSE
//  Receive-side PRBS31 (x^31+x^28+1) pattern checker, the counterpart of the PRBS31 generator.
//  Self-synchronises an LFSR to an incoming serial bit stream, then flags and counts bit errors.
//  Used in the tt_um_ top level for link and loopback BER test: din from ui_in, status to uo_out/uio_out.
// PARAMETERS
//  LOCK_THRESH   32  consecutive correct bits required after seeding before `locked` asserts (1..255)
//  LOSS_WINDOW   64  length, in valid bits, of the loss-of-lock observation window (2..255)
//  LOSS_THRESH   4   errors within one window that drop lock (1..LOSS_WINDOW)
//  ERR_W         16  width of err_count (saturating)
//  BIT_W         32  width of bit_count (saturating)
//  INVERT        0   1 = incoming stream is inverted PRBS31; din is XORed with 1 before all processing
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      reset, asynchronous assert, active-low
//  din        in   1      received serial bit
//  din_valid  in   1      din is sampled on clk edges where din_valid=1; otherwise nothing advances
//  clear      in   1      synchronous clear of err_count, bit_count and the loss window; lock state is kept
//  locked     out  1      checker is synchronised to the stream
//  err_pulse  out  1      one-cycle pulse: the previous sampled bit mismatched while locked
//  err_count  out  ERR_W  mismatches counted while locked; saturates at all-ones
//  bit_count  out  BIT_W  bits checked while locked; saturates at all-ones
// BEHAVIOUR
//  Reset: state=ACQUIRE; lfsr=0; fill=0; run=0; locked=0; err_pulse=0; err_count=0; bit_count=0.
//  LFSR s[30:0]: pred = s[30]^s[27]. Every update shifts left by one bit: s <= {s[29:0], x}.
//  Only edges where din_valid=1 advance the FSM and counters. err_pulse is 0 on all other edges.
//  ACQUIRE: x=din; fill++.
//   - After the 31st bit: if the new s==0, set fill=0 and stay in ACQUIRE, so all-zero lock is impossible.
//   - Otherwise set run=0 and go to VERIFY.
//  VERIFY: x=din.
//   - din==pred: run++. When run reaches LOCK_THRESH, go to LOCKED; locked=1 on that same edge.
//     With continuous valid, locked rises on the edge of the (31+LOCK_THRESH)th valid bit.
//   - Mismatch: fill=0 and go to ACQUIRE. Nothing is counted.
//  LOCKED: x=pred (a flywheel, so errors never corrupt the LFSR).
//   - bit_count++ and win++. On mismatch: err_pulse=1 on the next edge, err_count++, werr++.
//   - When werr reaches LOSS_THRESH: locked=0, go to ACQUIRE with fill=0. That error is counted.
//   - When win reaches LOSS_WINDOW without loss: win=0 and werr=0.
//  Loss of lock keeps err_count and bit_count. Errors in ACQUIRE and VERIFY are never counted.
//  clear takes priority over a simultaneous increment: counters become 0 and that bit is not counted.
//   err_pulse still fires. clear does not change state or lfsr.
//  Counters saturate and never wrap. din_valid gaps of any length do not affect lock or counts.
//  Asserting rst_n mid-operation forces all reset values immediately. Reacquisition starts after release.
//  All outputs are registered. The design has no combinational paths from input to output.
// STRUCTURE
//  prbs_pkg contains:
//   - PRBS31_LEN=31 and the tap indices TAP_A=30 and TAP_B=27.
//   - typedef enum {ACQUIRE, VERIFY, LOCKED} prbs_chk_state_t.
//   - function prbs31_next(s) returning pred.
//  Sub-module prbs31_lfsr (31-bit shift register with load-bit select) is shared with the generator.
//  This module contains the FSM, the fill/run/window counters and the saturating error and bit counters.
// TESTING
//  1 Clean PRBS31 from seed 31'h1, din_valid=1 always, LOCK_THRESH=32 -> locked rises after the 63rd bit.
//    err_count=0 after 10000 bits; bit_count=9937.
//  2 Same stream with din_valid=1 one cycle in three -> identical lock point (63 valid bits) and counts.
//  3 After lock, flip bit 500 -> exactly one err_pulse, err_count=1, locked stays 1.
//  4 After lock, flip 8 bits within 20 bits -> locked falls at the 4th flip with err_count=4.
//    Clean bits resume -> relock after 63 more clean valid bits; err_count still 4.
//  5 din=0 constant for 1000 bits -> locked never asserts. INVERT=1 with an inverted clean stream -> behaves as scenario 1.
//  6 clear on the same edge as an error -> err_count=0 and err_pulse=1.
//    rst_n low mid-lock -> all outputs 0 asynchronously.
//    ERR_W=4 with 20 errors -> err_count holds 4'hF.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared PRBS31 (x^31 + x^28 + 1) definitions used by the generator and the checker.
package prbs_pkg;

    localparam int unsigned PRBS31_LEN = 31;
    localparam int unsigned TAP_A      = 30;
    localparam int unsigned TAP_B      = 27;

    typedef enum logic [1:0] {
        ACQUIRE,
        VERIFY,
        LOCKED
    } prbs_chk_state_t;

    // Next bit of the sequence given the last 31 bits, newest in s[0].
    function automatic logic prbs31_next(input logic [PRBS31_LEN-1:0] s);
        return s[TAP_A] ^ s[TAP_B];
    endfunction

endpackage

// File: rtl/prbs31_checker_if.sv
// Serial data input and status outputs of the PRBS31 checker.
interface prbs31_checker_if #(
    parameter int unsigned ERR_W = 16,
    parameter int unsigned BIT_W = 32
) ();

    logic             din;
    logic             din_valid;
    logic             clear;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [BIT_W-1:0] bit_count;

    modport master (
        output din, din_valid, clear,
        input  locked, err_pulse, err_count, bit_count
    );

    modport slave (
        input  din, din_valid, clear,
        output locked, err_pulse, err_count, bit_count
    );

endinterface

// File: rtl/prbs31_lfsr.sv
// 31-bit PRBS shift register; each enabled edge shifts in either an external bit or its own
// feedback bit.
module prbs31_lfsr
    import prbs_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  sel_fb,
    input  logic                  bit_in,
    output logic [PRBS31_LEN-1:0] state,
    output logic                  pred
);

    logic [PRBS31_LEN-1:0] s_q, s_d;

    always_comb begin
        pred = prbs31_next(s_q);
        s_d  = s_q;
        if (en) begin
            s_d = {s_q[PRBS31_LEN-2:0], (sel_fb ? pred : bit_in)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end

    assign state = s_q;

endmodule

// File: rtl/prbs31_checker.sv
// PRBS31 receive checker: seeds an LFSR from the incoming stream, verifies it, then freewheels
// and counts mismatches, dropping lock when too many errors land in one observation window.
module prbs31_checker
    import prbs_pkg::*;
#(
    parameter int unsigned LOCK_THRESH = 32,
    parameter int unsigned LOSS_WINDOW = 64,
    parameter int unsigned LOSS_THRESH = 4,
    parameter int unsigned ERR_W       = 16,
    parameter int unsigned BIT_W       = 32,
    parameter int unsigned INVERT      = 0
) (
    input logic              clk,
    input logic              rst_n,
    prbs31_checker_if.slave  bus
);

    localparam logic [ERR_W-1:0] ErrOne = 1;
    localparam logic [BIT_W-1:0] BitOne = 1;

    prbs_chk_state_t       state_q, state_d;
    logic [4:0]            fill_q, fill_d;
    logic [7:0]            run_q, run_d;
    logic [7:0]            win_q, win_d;
    logic [7:0]            werr_q, werr_d;
    logic                  locked_q, locked_d;
    logic                  err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]      err_cnt_q, err_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;

    logic                  din_eff;
    logic                  pred;
    logic                  mismatch;
    logic [PRBS31_LEN-1:0] lfsr_state;
    logic [PRBS31_LEN-1:0] seed_next;

    assign din_eff   = bus.din ^ (INVERT != 0);
    assign mismatch  = din_eff ^ pred;
    assign seed_next = {lfsr_state[PRBS31_LEN-2:0], din_eff};

    // Once locked the register runs on its own feedback so line errors never corrupt it.
    prbs31_lfsr u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (bus.din_valid),
        .sel_fb (state_q == LOCKED),
        .bit_in (din_eff),
        .state  (lfsr_state),
        .pred   (pred)
    );

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        run_d       = run_q;
        win_d       = win_q;
        werr_d      = werr_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        bit_cnt_d   = bit_cnt_q;

        if (bus.din_valid) begin
            unique case (state_q)
                ACQUIRE: begin
                    if (fill_q == 5'(PRBS31_LEN - 1)) begin
                        fill_d = '0;
                        // An all-zero seed would lock onto a dead line; keep filling instead.
                        if (seed_next != '0) begin
                            run_d   = '0;
                            state_d = VERIFY;
                        end
                    end else begin
                        fill_d = fill_q + 5'd1;
                    end
                end
                VERIFY: begin
                    if (!mismatch) begin
                        run_d = run_q + 8'd1;
                        if (run_d == 8'(LOCK_THRESH)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            win_d    = '0;
                            werr_d   = '0;
                        end
                    end else begin
                        fill_d  = '0;
                        state_d = ACQUIRE;
                    end
                end
                LOCKED: begin
                    err_pulse_d = mismatch;
                    if (!bus.clear) begin
                        if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + BitOne;
                        win_d = win_q + 8'd1;
                        if (mismatch) begin
                            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ErrOne;
                            werr_d = werr_q + 8'd1;
                        end
                        if (mismatch && (werr_d == 8'(LOSS_THRESH))) begin
                            locked_d = 1'b0;
                            state_d  = ACQUIRE;
                            fill_d   = '0;
                        end else if (win_d == 8'(LOSS_WINDOW)) begin
                            win_d  = '0;
                            werr_d = '0;
                        end
                    end
                end
                default: begin
                    state_d  = ACQUIRE;
                    fill_d   = '0;
                    locked_d = 1'b0;
                end
            endcase
        end

        if (bus.clear) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
            win_d     = '0;
            werr_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACQUIRE;
            fill_q      <= '0;
            run_q       <= '0;
            win_q       <= '0;
            werr_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            run_q       <= run_d;
            win_q       <= win_d;
            werr_q      <= werr_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_cnt_q;
    assign bus.bit_count = bit_cnt_q;

endmodule
